// File: rtl/pong_pkg.sv
// pong_pkg: state and direction encodings shared by the ball sequencer
package pong_pkg;
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, SCORED, OVER} state_t;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b11;
  localparam logic [1:0] DIR_ZERO = 2'b00;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running step divider, held at zero while clr is high
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] count;
  assign tick = count == CW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= (clr || tick) ? '0 : count + 1'b1;
endmodule

// File: rtl/ball_ctrl.sv
// ball_ctrl: pong sequencer driving the ball position block, bounces, misses and scoring
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int BIT_OF_WIDTH = 3,
  parameter int TICK_DIV     = 4,
  parameter int PADDLE_LEN   = 3,
  parameter int SERVE_TICKS  = 2,
  parameter int WIN_SCORE    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [2*BIT_OF_WIDTH-1:0] pos,
  input  logic [BIT_OF_WIDTH-1:0]   paddle_l,
  input  logic [BIT_OF_WIDTH-1:0]   paddle_r,
  output logic                      en,
  output logic [3:0]                vector,
  output logic [3:0]                score_l,
  output logic [3:0]                score_r,
  output logic                      point_l,
  output logic                      point_r,
  output logic                      game_over
);
  localparam int W = BIT_OF_WIDTH;
  localparam int HOLD = SERVE_TICKS * TICK_DIV;
  localparam int HW = $clog2(HOLD);
  localparam logic [W-1:0] LAST = '1;
  localparam logic [W:0] SPAN = (W+1)'(PADDLE_LEN - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  state_t state;
  logic [1:0] dx, dy, dx_next, dy_next;
  logic [HW-1:0] hold;
  logic [W-1:0] x, y;
  logic tick, miss, clr, in_l, in_r;
  assign x = pos[2*W-1:W];
  assign y = pos[W-1:0];
  assign miss = state == PLAY && (x == '0 || x == LAST);
  assign clr = !(state == SERVE || state == PLAY) || miss;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .clr(clr), .tick(tick));
  // paddle spans are widened by one bit so a paddle near the bottom clips instead of wrapping
  assign in_l = {1'b0, y} >= {1'b0, paddle_l} && {1'b0, y} <= {1'b0, paddle_l} + SPAN;
  assign in_r = {1'b0, y} >= {1'b0, paddle_r} && {1'b0, y} <= {1'b0, paddle_r} + SPAN;
  always_comb begin
    dy_next = ((y == '0 && dy == DIR_NEG) || (y == LAST && dy == DIR_POS)) ?
              (dy == DIR_POS ? DIR_NEG : DIR_POS) : dy;
    dx_next = (x == W'(1) && dx == DIR_NEG && in_l) ? DIR_POS :
              (x == LAST - 1'b1 && dx == DIR_POS && in_r) ? DIR_NEG : dx;
    vector  = (state == PLAY && tick && !miss) ? {dx_next, dy_next} : {DIR_ZERO, DIR_ZERO};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      en        <= 1'b0;
      score_l   <= '0;
      score_r   <= '0;
      point_l   <= 1'b0;
      point_r   <= 1'b0;
      game_over <= 1'b0;
      dx        <= DIR_POS;
      dy        <= DIR_POS;
      hold      <= '0;
    end else begin
      point_l <= 1'b0;
      point_r <= 1'b0;
      case (state)
        IDLE, OVER: if (start) begin
          state     <= SERVE;
          en        <= 1'b1;
          game_over <= 1'b0;
          score_l   <= '0;
          score_r   <= '0;
          dx        <= DIR_POS;
          dy        <= DIR_POS;
          hold      <= '0;
        end
        SERVE: if (tick) begin
          hold  <= hold == HW'(SERVE_TICKS - 1) ? '0 : hold + 1'b1;
          state <= hold == HW'(SERVE_TICKS - 1) ? PLAY : SERVE;
        end
        PLAY: if (miss) begin
          state   <= SCORED;
          en      <= 1'b0;
          hold    <= '0;
          point_r <= x == '0;
          point_l <= x == LAST;
          score_r <= (x == '0 && score_r != WIN) ? score_r + 1'b1 : score_r;
          score_l <= (x == LAST && score_l != WIN) ? score_l + 1'b1 : score_l;
          dx      <= x == '0 ? DIR_NEG : DIR_POS;
          dy      <= DIR_POS;
        end else if (tick) begin
          dx <= dx_next;
          dy <= dy_next;
        end
        SCORED: if (hold == HW'(HOLD - 1)) begin
          hold      <= '0;
          state     <= (score_l == WIN || score_r == WIN) ? OVER : SERVE;
          game_over <= score_l == WIN || score_r == WIN;
          en        <= !(score_l == WIN || score_r == WIN);
        end else hold <= hold + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ball_ctrl.sv
// tb_ball_ctrl: randomized and directed checks of ball_ctrl against a rule-level game model
module tb_ball_ctrl;
  localparam int W = 3, TD = 4, PL = 3, ST = 2, WIN = 5, LAST = 7, HOLD = ST * TD;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_SCORED = 3, M_OVER = 4;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [2*W-1:0] pos;
  logic [W-1:0] paddle_l = '0, paddle_r = '0;
  logic en, point_l, point_r, game_over;
  logic [3:0] vector, score_l, score_r;
  logic ovr = 1'b0;
  logic [2*W-1:0] ovr_pos = '0;
  int checks = 0, failures = 0;
  int m_mode, m_cyc, m_dx, m_dy, m_sl, m_sr;
  bit m_pl, m_pr;

  ball_ctrl #(.BIT_OF_WIDTH(W), .TICK_DIV(TD), .PADDLE_LEN(PL), .SERVE_TICKS(ST), .WIN_SCORE(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pos(pos), .paddle_l(paddle_l), .paddle_r(paddle_r),
    .en(en), .vector(vector), .score_l(score_l), .score_r(score_r),
    .point_l(point_l), .point_r(point_r), .game_over(game_over));

  always #5 clk = ~clk;

  // position block: centre when disabled, otherwise step by the signed vector
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pos <= {3'd4, 3'd4};
    else if (ovr) pos <= ovr_pos;
    else if (!en) pos <= {3'd4, 3'd4};
    else pos <= {pos[5:3] + {vector[3], vector[3:2]}, pos[2:0] + {vector[1], vector[1:0]}};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input int d);
    return d > 0 ? 2'b01 : (d < 0 ? 2'b11 : 2'b00);
  endfunction

  function automatic bit on_paddle(input int yy, input int top);
    return yy >= top && yy <= top + PL - 1;
  endfunction

  function automatic bit m_tick();
    return (m_mode == M_SERVE || m_mode == M_PLAY) && (m_cyc % TD == TD - 1);
  endfunction

  function automatic bit m_miss();
    return m_mode == M_PLAY && (int'(pos[5:3]) == 0 || int'(pos[5:3]) == LAST);
  endfunction

  function automatic int m_dyn();
    int yy = int'(pos[2:0]);
    return ((yy == 0 && m_dy < 0) || (yy == LAST && m_dy > 0)) ? -m_dy : m_dy;
  endfunction

  function automatic int m_dxn();
    int xx = int'(pos[5:3]);
    int yy = int'(pos[2:0]);
    if (xx == 1 && m_dx < 0 && on_paddle(yy, int'(paddle_l))) return 1;
    if (xx == LAST - 1 && m_dx > 0 && on_paddle(yy, int'(paddle_r))) return -1;
    return m_dx;
  endfunction

  function automatic logic [3:0] m_vec();
    return (m_mode == M_PLAY && m_tick() && !m_miss()) ? {enc(m_dxn()), enc(m_dyn())} : 4'b0000;
  endfunction

  task automatic m_reset();
    m_mode = M_IDLE; m_cyc = 0; m_dx = 1; m_dy = 1; m_sl = 0; m_sr = 0; m_pl = 0; m_pr = 0;
  endtask

  // advance the model across the coming clock edge using the inputs present now
  task automatic m_update();
    int xx = int'(pos[5:3]);
    bit tk = m_tick();
    int nx = m_dxn();
    int ny = m_dyn();
    m_pl = 0;
    m_pr = 0;
    case (m_mode)
      M_IDLE, M_OVER: if (start) begin
        if (m_mode == M_OVER) begin m_sl = 0; m_sr = 0; end
        m_mode = M_SERVE; m_cyc = 0; m_dx = 1; m_dy = 1;
      end
      M_SERVE: if (m_cyc == HOLD - 1) begin m_mode = M_PLAY; m_cyc = 0; end else m_cyc++;
      M_PLAY: if (xx == 0) begin
        m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1; m_pr = 1;
        m_mode = M_SCORED; m_cyc = 0; m_dx = -1; m_dy = 1;
      end else if (xx == LAST) begin
        m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1; m_pl = 1;
        m_mode = M_SCORED; m_cyc = 0; m_dx = 1; m_dy = 1;
      end else begin
        if (tk) begin m_dx = nx; m_dy = ny; end
        m_cyc++;
      end
      M_SCORED: if (m_cyc == HOLD - 1) begin
        m_mode = (m_sl == WIN || m_sr == WIN) ? M_OVER : M_SERVE; m_cyc = 0;
      end else m_cyc++;
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic step();
    m_update();
    @(negedge clk);
    #1;
    chk("en", en, (m_mode == M_SERVE || m_mode == M_PLAY));
    chk("vector", vector, m_vec());
    chk("score_l", score_l, m_sl);
    chk("score_r", score_r, m_sr);
    chk("point_l", point_l, m_pl);
    chk("point_r", point_r, m_pr);
    chk("game_over", game_over, m_mode == M_OVER);
  endtask

  // park the ball at (px,py) so it is seen on the next PLAY tick; returns on that tick cycle
  task automatic place(input int px, input int py);
    int g = 0;
    while (!(m_mode == M_PLAY && m_cyc % TD == TD - 2) && g < 100) begin step(); g++; end
    if (g >= 100) chk("place_timeout", 0, 1);
    ovr_pos = {3'(px), 3'(py)};
    ovr = 1'b1;
    step();
    ovr = 1'b0;
  endtask

  initial begin
    int g;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_en", en, 0); chk("rst_vector", vector, 0); chk("rst_score_l", score_l, 0);
    chk("rst_score_r", score_r, 0); chk("rst_points", {point_l, point_r}, 0); chk("rst_over", game_over, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    step(); step();
    start = 1'b1; step(); start = 1'b0;
    chk("serve_en", en, 1);
    for (int i = 0; i < 7; i++) begin step(); chk("serve_hold", {en, vector}, 5'b10000); end
    repeat (4) step();
    chk("first_tick", vector, 4'b0101);
    place(3, 7);   chk("top_wall", vector, 4'b0111);
    paddle_r = 2; place(6, 3); chk("right_paddle", vector, 4'b1111);
    paddle_l = 2; place(1, 3); chk("left_paddle", vector, 4'b0111);
    place(6, 3);   chk("right_paddle2", vector, 4'b1111);
    paddle_l = 5; place(1, 3); chk("paddle_miss_step", vector, 4'b1111);
    step(); step();
    chk("miss_point_r", point_r, 1); chk("miss_score_r", score_r, 1); chk("miss_en", en, 0);
    step(); chk("point_pulse_end", point_r, 0);
    repeat (6) step();
    chk("scored_hold", en, 0);
    step(); chk("reserve_en", en, 1);
    place(4, 4);   chk("serve_toward_loser", vector, 4'b1101);
    paddle_l = 7; place(1, 0); chk("paddle_clip", vector, 4'b1101);
    for (int i = 0; i < 5; i++) begin place(7, 4); chk("miss_priority", vector, 0); end
    step(); chk("win_point_l", point_l, 1); chk("win_score_l", score_l, 5);
    repeat (7) step();
    step(); chk("game_over", game_over, 1); chk("over_en", en, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("restart_scores", {score_l, score_r}, 0); chk("restart_en", en, 1); chk("restart_over", game_over, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) paddle_l = W'($urandom);
      if ($urandom_range(15) == 0) paddle_r = W'($urandom);
      start = $urandom_range(9) == 0;
      ovr = $urandom_range(31) == 0;
      ovr_pos = 6'($urandom);
      step();
    end
    ovr = 1'b0;
    g = 0;
    while (m_mode != M_PLAY && g < 200) begin start = 1'b1; step(); g++; end
    start = 1'b0;
    if (g >= 200) chk("play_timeout", 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en", en, 0); chk("async_vector", vector, 0); chk("async_score_l", score_l, 0);
    chk("async_score_r", score_r, 0); chk("async_over", game_over, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    start = 1'b1; step(); start = 1'b0;
    repeat (40) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
